psum_gbf_drain_sink: RTL and testbench
======================================

# psum_gbf_drain_sink

Receiving end of the psum_gbf read-out path. After each psum_gbf buffer swap, the drain controller issues reads to the idle bank (gbf_r_en/gbf_r_addr, each address held for two enable cycles). This block captures the returned rows, drops duplicate reads of the same address, and buffers the rows in a small FIFO. It then streams them to the on-chip SRAM write port under a valid/ready handshake, assigning each tile its own SRAM address window.

## Interface
Parameters:
- GBF_DATA_BITWIDTH, 512, width of one psum_gbf row
- GBF_ADDR_BITWIDTH, 5, psum_gbf row address width
- DEPTH, 32, rows per tile (one psum_gbf bank)
- SRAM_ADDR_BITWIDTH, 16, SRAM row address width
- FIFO_DEPTH, 4, capture FIFO entries (power of 2)

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high
- gbf_r_en  in  1  read enable issued to psum_gbf by the drain controller
- gbf_r_addr  in  GBF_ADDR_BITWIDTH  read address issued with gbf_r_en
- gbf_r_data  in  GBF_DATA_BITWIDTH  psum_gbf read data, valid one cycle after gbf_r_en is sampled
- conv_finish  in  1  level; no further tiles follow
- sram_ready  in  1  SRAM accepts the current write
- sram_w_en  out  1  write valid
- sram_w_addr  out  SRAM_ADDR_BITWIDTH  tile_count*DEPTH + row address
- sram_w_data  out  GBF_DATA_BITWIDTH  row data
- tile_done  out  1  one-cycle pulse when row DEPTH-1 of a tile is written
- tile_count  out  SRAM_ADDR_BITWIDTH  number of completed tiles
- drain_busy  out  1  state is COLLECT or DRAIN, or the FIFO is non-empty
- overflow  out  1  sticky; a capture was dropped because the FIFO was full
- conv_done  out  1  sticky; all tiles are flushed and conv_finish has been seen

## Operation
- Stage 1 registers gbf_r_en and gbf_r_addr as cap_v and cap_addr. On the next edge, gbf_r_data pairs with {cap_v, cap_addr}.
- Dedup rule: a capture is accepted only if last_valid=0 or cap_addr != last_addr.
  - On accept: last_addr <= cap_addr, last_valid <= 1.
  - If cap_addr == DEPTH-1, last_valid <= 0 instead, so the next tile's row 0 is accepted.
- An accepted capture pushes {cap_addr, gbf_r_data} into the FIFO.
- FIFO full on push: the entry is dropped and overflow is set. It clears only on reset. A simultaneous pop frees a slot first, so push+pop on a full FIFO succeeds.
- The FIFO is show-ahead. sram_w_en = !empty. sram_w_data and sram_w_addr come from the head entry. Pop occurs when sram_w_en && sram_ready.
- The SRAM address uses the pop-side tile_count, so entries of the next tile already in the FIFO are addressed correctly.
- Popping an entry with addr DEPTH-1:
  - tile_done pulses in the following cycle.
  - tile_count increments, modulo 2^SRAM_ADDR_BITWIDTH.
- Writes are issued in capture order. Row addresses are not reordered and gaps are not filled.

FSM states: IDLE, COLLECT, DRAIN, DONE.
- IDLE: an accepted capture moves to COLLECT. If the FIFO is empty and conv_finish=1, move to DONE.
- COLLECT: accepting addr DEPTH-1 moves to DRAIN.
- DRAIN: captures are still accepted. The pop of addr DEPTH-1 moves to COLLECT if the FIFO is still non-empty after the pop or a capture is accepted in the same cycle, else to IDLE.
- DONE: terminal. conv_done=1 and all captures are ignored. Exit only by reset.
- conv_finish seen in COLLECT or DRAIN is latched and takes effect on the next entry to IDLE.
- Reset mid-tile: FIFO is flushed, the FSM returns to IDLE, and tile_count returns to 0. Partial tiles are discarded.

## Timing
- Reset values: sram_w_en=0, sram_w_addr=0, sram_w_data=0, tile_done=0, tile_count=0, drain_busy=0, overflow=0, conv_done=0. FSM is IDLE and the FIFO is empty.
- Latency when sram_ready=1:
  - gbf_r_en sampled at edge N.
  - gbf_r_data sampled and pushed at edge N+1.
  - sram_w_en high after edge N+1.
  - Write accepted at edge N+2.
- Throughput: one push and one pop per cycle. A two-cycle-per-row read pattern never fills the FIFO while sram_ready stays high.
- sram_w_addr and sram_w_data stay stable while sram_w_en=1 and sram_ready=0.
- tile_done goes high the cycle after the popping edge, for exactly one cycle.
- conv_done goes high the cycle after the transition to DONE.

## Test plan
- Single tile: drive rows 0..31, each with gbf_r_en held two cycles, data = row index replicated; sram_ready=1 -> exactly 32 writes to addresses 0..31 with matching data, one tile_done, tile_count=1, overflow=0.
- Backpressure: same stimulus with sram_ready=0 for 20 cycles -> FIFO fills, overflow=1, held outputs stable. With sram_ready toggling 1/0 instead -> no drops, 32 writes, overflow=0.
- Back-to-back tiles: second tile's row 0 captured while tile 1 is in DRAIN -> second tile written to addresses 32..63, tile_count=2, two tile_done pulses.
- Dedup edge: row 31 then row 0 of the next tile, each read twice -> exactly one write each. Row 5 read four times in a row -> one write.
- conv_finish asserted during COLLECT -> remaining rows flushed, then FSM enters DONE, conv_done=1, and later gbf_r_en activity produces no writes.
- Reset asserted after 10 rows captured with sram_ready=0 -> all outputs at reset values, a following full tile writes to addresses 0..31.

Source files
------------

// File: rtl/psum_gbf_drain_sink.sv
// Receive side of the psum_gbf read-out path: captures returned rows, drops repeat reads,
// buffers them in a show-ahead FIFO and streams them to SRAM with a per-tile address window.
module psum_gbf_drain_sink #(
    parameter int GBF_DATA_BITWIDTH  = 512,
    parameter int GBF_ADDR_BITWIDTH  = 5,
    parameter int DEPTH              = 32,
    parameter int SRAM_ADDR_BITWIDTH = 16,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          gbf_r_en,
    input  logic [GBF_ADDR_BITWIDTH-1:0]  gbf_r_addr,
    input  logic [GBF_DATA_BITWIDTH-1:0]  gbf_r_data,
    input  logic                          conv_finish,
    input  logic                          sram_ready,
    output logic                          sram_w_en,
    output logic [SRAM_ADDR_BITWIDTH-1:0] sram_w_addr,
    output logic [GBF_DATA_BITWIDTH-1:0]  sram_w_data,
    output logic                          tile_done,
    output logic [SRAM_ADDR_BITWIDTH-1:0] tile_count,
    output logic                          drain_busy,
    output logic                          overflow,
    output logic                          conv_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [GBF_ADDR_BITWIDTH-1:0]  LAST_ROW = GBF_ADDR_BITWIDTH'(DEPTH - 1);
    localparam logic [PTR_W:0]                FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [SRAM_ADDR_BITWIDTH-1:0] DEPTH_S  = SRAM_ADDR_BITWIDTH'(DEPTH);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic                         cap_v, prv_v, last_valid, fin_seen;
    logic [GBF_ADDR_BITWIDTH-1:0] cap_addr, prv_addr, last_addr, head_addr;
    logic [GBF_ADDR_BITWIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [GBF_DATA_BITWIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W:0]               wr_ptr, rd_ptr, count;
    logic                         empty, full, accept, push, pop, head_last;

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign head_addr = fifo_addr[rd_ptr[PTR_W-1:0]];
    assign head_last = (head_addr == LAST_ROW);

    // The controller holds each address for two enables, so a capture repeating the one
    // just before it is always a duplicate, even right after the last row cleared last_valid.
    assign accept = cap_v && (state != DONE)
                 && (!last_valid || (cap_addr != last_addr))
                 && !(prv_v && (prv_addr == cap_addr));
    assign pop    = !empty && sram_ready;
    assign push   = accept && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_v      <= 1'b0;
            cap_addr   <= '0;
            prv_v      <= 1'b0;
            prv_addr   <= '0;
            last_valid <= 1'b0;
            last_addr  <= '0;
        end else begin
            cap_v    <= gbf_r_en;
            cap_addr <= gbf_r_addr;
            prv_v    <= cap_v;
            prv_addr <= cap_addr;
            if (accept) begin
                last_addr  <= cap_addr;
                last_valid <= (cap_addr != LAST_ROW);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PTR_W-1:0]] <= cap_addr;
            fifo_data[wr_ptr[PTR_W-1:0]] <= gbf_r_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            tile_count <= '0;
            tile_done  <= 1'b0;
            fin_seen   <= 1'b0;
            state      <= IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (accept && !push) overflow <= 1'b1;
            if (pop && head_last) tile_count <= tile_count + SRAM_ADDR_BITWIDTH'(1);
            tile_done <= pop && head_last;
            if (conv_finish && (state == COLLECT || state == DRAIN)) fin_seen <= 1'b1;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (cap_addr == LAST_ROW) ? DRAIN : COLLECT;
                else if (empty && (conv_finish || fin_seen))
                    state_nxt = DONE;
            end
            COLLECT: if (accept && cap_addr == LAST_ROW) state_nxt = DRAIN;
            // Leftover entries or a fresh capture mean the next tile has already started.
            DRAIN: if (pop && head_last) state_nxt = (count > 1 || accept) ? COLLECT : IDLE;
            DONE: state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Tile base comes from the pop-side count so early next-tile entries land correctly.
    assign sram_w_en   = !empty;
    assign sram_w_data = empty ? '0 : fifo_data[rd_ptr[PTR_W-1:0]];
    assign sram_w_addr = empty ? '0 : tile_count * DEPTH_S + SRAM_ADDR_BITWIDTH'(head_addr);
    assign drain_busy  = (state == COLLECT) || (state == DRAIN) || !empty;
    assign conv_done   = (state == DONE);
endmodule

// File: tb/tb_psum_gbf_drain_sink.sv
// Directed bench for psum_gbf_drain_sink: single tile, backpressure/overflow, mid-tile reset,
// toggling ready, back-to-back tiles with duplicate reads, and conv_finish into DONE.
module tb_psum_gbf_drain_sink;
    localparam int DW = 512, AW = 5, DEPTH = 32, SW = 16;

    logic          clk = 1'b0, reset = 1'b1;
    logic          gbf_r_en = 1'b0, conv_finish = 1'b0, sram_ready = 1'b1;
    logic [AW-1:0] gbf_r_addr = '0;
    logic [DW-1:0] gbf_r_data = '0;
    logic          sram_w_en, tile_done, drain_busy, overflow, conv_done;
    logic [SW-1:0] sram_w_addr, tile_count;
    logic [DW-1:0] sram_w_data;

    int passed = 0, total = 0, n_done = 0;
    logic [SW-1:0] wq_addr[$];
    logic [DW-1:0] wq_data[$];
    logic [2:0]    salt = '0, prev_salt = '0;
    logic [AW-1:0] prev_addr = '0;
    bit            toggle = 1'b0;

    always #5 clk = ~clk;

    psum_gbf_drain_sink dut (
        .clk(clk), .reset(reset), .gbf_r_en(gbf_r_en), .gbf_r_addr(gbf_r_addr),
        .gbf_r_data(gbf_r_data), .conv_finish(conv_finish), .sram_ready(sram_ready),
        .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data),
        .tile_done(tile_done), .tile_count(tile_count), .drain_busy(drain_busy),
        .overflow(overflow), .conv_done(conv_done)
    );

    // A write happens at the next posedge whenever valid and ready are both high mid-cycle.
    always @(negedge clk) begin
        if (!reset && sram_w_en && sram_ready) begin
            wq_addr.push_back(sram_w_addr);
            wq_data.push_back(sram_w_data);
        end
        if (tile_done) n_done++;
    end

    function automatic logic [DW-1:0] mk(input logic [2:0] s, input logic [AW-1:0] a);
        return {64{s, a}};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Read data returns one cycle after the enable, so each step drives the previous read's row.
    task automatic step(input logic en, input logic [AW-1:0] a);
        gbf_r_en   = en;
        gbf_r_addr = a;
        gbf_r_data = mk(prev_salt, prev_addr);
        if (toggle) sram_ready = !sram_ready;
        prev_salt = salt;
        prev_addr = a;
        @(posedge clk); #1;
    endtask

    task automatic read_row(input int r, input int times);
        repeat (times) step(1'b1, AW'(r));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0);
    endtask

    task automatic check_reset();
        check("rst_w_en", sram_w_en, 0);
        check("rst_w_addr", sram_w_addr, 0);
        check("rst_w_data", sram_w_data, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_tile_count", tile_count, 0);
        check("rst_busy", drain_busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_conv_done", conv_done, 0);
    endtask

    task automatic check_tile(input int qb, input logic [SW-1:0] abase, input logic [2:0] s);
        for (int r = 0; r < DEPTH; r++) begin
            logic [SW-1:0] oa;
            logic [DW-1:0] od;
            oa = (qb + r < wq_addr.size()) ? wq_addr[qb + r] : 'x;
            od = (qb + r < wq_data.size()) ? wq_data[qb + r] : 'x;
            check("wr_addr", oa, abase + SW'(r));
            check("wr_data", od, mk(s, AW'(r)));
        end
    endtask

    initial begin
        int qb, db;

        repeat (2) @(posedge clk);
        #1;
        check_reset();
        reset = 1'b0;

        // Single tile, ready high: latency then 32 in-order writes
        salt = 3'd1; qb = wq_addr.size(); db = n_done;
        step(1'b1, 0);
        check("lat_en_early", sram_w_en, 0);
        step(1'b1, 0);
        check("lat_en", sram_w_en, 1);
        check("lat_addr", sram_w_addr, 0);
        check("lat_data", sram_w_data, mk(3'd1, 0));
        for (int r = 1; r < DEPTH; r++) read_row(r, 2);
        idle(6);
        check("t1_count", wq_addr.size() - qb, 32);
        check_tile(qb, 0, 3'd1);
        check("t1_done", n_done - db, 1);
        check("t1_tile_count", tile_count, 1);
        check("t1_overflow", overflow, 0);
        check("t1_busy", drain_busy, 0);
        check("t1_conv_done", conv_done, 0);

        // Stalled SRAM: head held stable while the FIFO fills and overflows
        salt = 3'd2; qb = wq_addr.size(); sram_ready = 1'b0;
        read_row(0, 2);
        for (int r = 1; r < 10; r++) begin
            read_row(r, 2);
            check("hold_en", sram_w_en, 1);
            check("hold_addr", sram_w_addr, 32);
            check("hold_data", sram_w_data, mk(3'd2, 0));
        end
        check("bp_overflow", overflow, 1);
        check("bp_busy", drain_busy, 1);
        check("bp_no_writes", wq_addr.size() - qb, 0);

        // Reset mid-tile discards everything
        gbf_r_en = 1'b0;
        reset = 1'b1;
        #1;
        check_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        sram_ready = 1'b1;

        // Toggling ready: no drops, window restarts at 0
        salt = 3'd3; qb = wq_addr.size(); toggle = 1'b1;
        for (int r = 0; r < DEPTH; r++) read_row(r, 2);
        idle(8);
        toggle = 1'b0; sram_ready = 1'b1;
        check("tg_count", wq_addr.size() - qb, 32);
        check_tile(qb, 0, 3'd3);
        check("tg_overflow", overflow, 0);
        check("tg_tile_count", tile_count, 1);

        // Back-to-back tiles; row 5 read four times, row 31 / next row 0 read twice each
        salt = 3'd4; qb = wq_addr.size(); db = n_done;
        for (int r = 0; r < DEPTH; r++) read_row(r, (r == 5) ? 4 : 2);
        salt = 3'd5;
        for (int r = 0; r < DEPTH; r++) read_row(r, 2);
        idle(6);
        check("bb_count", wq_addr.size() - qb, 64);
        check_tile(qb, 32, 3'd4);
        check_tile(qb + 32, 64, 3'd5);
        check("bb_done", n_done - db, 2);
        check("bb_tile_count", tile_count, 3);
        check("bb_overflow", overflow, 0);

        // conv_finish pulsed in COLLECT is latched; tile flushes, then DONE ignores reads
        salt = 3'd6; qb = wq_addr.size();
        for (int r = 0; r < 10; r++) read_row(r, 2);
        conv_finish = 1'b1;
        read_row(10, 2);
        conv_finish = 1'b0;
        check("fin_not_yet", conv_done, 0);
        for (int r = 11; r < DEPTH; r++) read_row(r, 2);
        idle(6);
        check("fin_count", wq_addr.size() - qb, 32);
        check_tile(qb, 96, 3'd6);
        check("fin_tile_count", tile_count, 4);
        check("fin_conv_done", conv_done, 1);
        check("fin_busy", drain_busy, 0);
        qb = wq_addr.size();
        for (int r = 0; r < 4; r++) read_row(r, 2);
        idle(4);
        check("done_no_writes", wq_addr.size() - qb, 0);
        check("done_w_en", sram_w_en, 0);
        check("done_sticky", conv_done, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
